// File: rtl/ysyx_24090012_lsu.sv
// Load/store unit between EXU and writeback.
// Takes one memory operation at a time from EXU and runs it as a single bus
// request/response toward data memory. It aligns store lanes, generates byte
// strobes, and sign- or zero-extends load data. The result goes to writeback
// through a valid/ready handshake. Every output is decoded from the FSM state
// and latched data only, so no input reaches an output combinationally.
module ysyx_24090012_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rsp_valid,
    input  logic        mem_rsp_err,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_rf_wen,
    output logic        out_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [3:0]  op_q;
    logic [4:0]  rd_q;
    logic        err_q;

    // The access is illegal if the size is 11, or if the address is not
    // aligned to the access size.
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
        logic bad;
        case (op[1:0])
            2'b00:   bad = 1'b0;
            2'b01:   bad = a[0];
            2'b10:   bad = (a != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte strobes for a store: a base mask per size, shifted to the addressed lane.
    function automatic logic [3:0] store_strb(input logic [3:0] op, input logic [1:0] a);
        logic [3:0] base;
        case (op[1:0])
            2'b00:   base = 4'b0001;
            2'b01:   base = 4'b0011;
            default: base = 4'b1111;
        endcase
        return base << a;
    endfunction

    // Shift the addressed lane down to bit 0, then extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [3:0] op,
                                                input logic [1:0] a);
        logic [31:0] v;
        logic [31:0] r;
        v = rdata >> {a, 3'b000};
        case (op[1:0])
            2'b00:   r = op[2] ? {24'b0, v[7:0]}   : {{24{v[7]}}, v[7:0]};
            2'b01:   r = op[2] ? {16'b0, v[15:0]}  : {{16{v[15]}}, v[15:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    // FSM and operand latches. A misaligned or illegal access skips the bus
    // and goes straight to DONE. A bus response is honoured only in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        addr_q  <= in_addr;
                        wdata_q <= in_wdata;
                        op_q    <= in_op;
                        rd_q    <= in_rd;
                        rdata_q <= '0;
                        err_q   <= is_misaligned(in_op, in_addr[1:0]);
                        state   <= is_misaligned(in_op, in_addr[1:0]) ? S_DONE : S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        rdata_q <= mem_rdata;
                        err_q   <= mem_rsp_err;
                        state   <= S_DONE;
                    end
                end
                default: begin
                    if (out_ready) state <= S_IDLE;
                end
            endcase
        end
    end

    logic in_req;
    logic is_store;
    logic in_done;
    logic load_ok;

    // Output decode. Payloads are forced to zero outside their valid state.
    always_comb begin
        in_req        = (state == S_REQ);
        in_done       = (state == S_DONE);
        is_store      = op_q[3];
        load_ok       = in_done & ~is_store & ~err_q;

        in_ready      = (state == S_IDLE);
        mem_req_valid = in_req;
        mem_addr      = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
        mem_wen       = in_req & is_store;
        mem_wdata     = (in_req & is_store) ? (wdata_q << {addr_q[1:0], 3'b000}) : 32'd0;
        mem_wstrb     = (in_req & is_store) ? store_strb(op_q, addr_q[1:0]) : 4'd0;

        out_valid     = in_done;
        out_rd        = in_done ? rd_q : 5'd0;
        out_err       = in_done & err_q;
        out_rf_wen    = load_ok;
        out_result    = load_ok ? load_extend(rdata_q, op_q, addr_q[1:0]) : 32'd0;
    end

endmodule

// File: tb/tb_ysyx_24090012_lsu.sv
// Testbench for ysyx_24090012_lsu: directed cases followed by randomized transactions.
module tb_ysyx_24090012_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [3:0]  in_op;
    logic [4:0]  in_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic        mem_rsp_err;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_rf_wen;
    logic        out_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ysyx_24090012_lsu dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_op(in_op), .in_rd(in_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_err(mem_rsp_err), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_rf_wen(out_rf_wen), .out_err(out_err)
    );

    // Opcodes: {is_store, is_unsigned, size}
    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0010;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: byte counts and arithmetic on byte lanes.
    function automatic int m_bytes(input logic [3:0] op);
        return (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit m_illegal(input logic [3:0] op, input logic [31:0] addr);
        if (op[1:0] == 2'b11) return 1'b1;
        return (int'(addr % 4) % m_bytes(op)) != 0;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [31:0] addr);
        logic [63:0] w;
        w = {32'd0, wd} << (8 * int'(addr % 4));
        return w[31:0];
    endfunction

    function automatic logic [31:0] m_strb(input logic [3:0] op, input logic [31:0] addr);
        int s;
        s = ((1 << m_bytes(op)) - 1) << int'(addr % 4);
        return 32'(s) & 32'hF;
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        logic [63:0] mask;
        logic [63:0] val;
        int nb;
        nb   = m_bytes(op);
        mask = (64'd1 << (8 * nb)) - 64'd1;
        val  = ({32'd0, rdata} >> (8 * int'(addr % 4))) & mask;
        if (!op[2] && nb < 4 && val[8 * nb - 1]) val = val | ~mask;
        return val[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one complete transaction with the given stall lengths, checking every cycle.
    task automatic do_op(input string nm, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdata, input int req_dly,
                         input int rsp_dly, input logic berr, input int out_dly,
                         input logic [4:0] rd);
        bit          bad;
        bit          eerr;
        logic [31:0] ew;
        logic [31:0] es;
        logic [31:0] eres;
        bad = m_illegal(op, addr);
        chk({nm, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_addr = addr; in_wdata = wd; in_op = op; in_rd = rd;
        tick();
        in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom; in_op = 4'($urandom);
        in_rd = 5'($urandom);
        if (!bad) begin
            ew = op[3] ? m_wdata(wd, addr) : 32'd0;
            es = op[3] ? m_strb(op, addr) : 32'd0;
            for (int i = 0; i <= req_dly; i++) begin
                chk({nm, ".req_valid"}, 32'(mem_req_valid), 32'd1);
                chk({nm, ".mem_addr"}, mem_addr, {addr[31:2], 2'b00});
                chk({nm, ".mem_wen"}, 32'(mem_wen), 32'(op[3]));
                chk({nm, ".mem_wdata"}, mem_wdata, ew);
                chk({nm, ".mem_wstrb"}, 32'(mem_wstrb), es);
                chk({nm, ".in_ready_req"}, 32'(in_ready), 32'd0);
                if (i == req_dly) begin
                    mem_req_ready = 1'b1;
                    // A response in the handshake cycle must be ignored.
                    mem_rsp_valid = 1'b1; mem_rsp_err = 1'b1; mem_rdata = 32'h5A5A5A5A;
                end
                tick();
            end
            mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
            for (int i = 0; i <= rsp_dly; i++) begin
                chk({nm, ".req_valid_wait"}, 32'(mem_req_valid), 32'd0);
                chk({nm, ".out_valid_wait"}, 32'(out_valid), 32'd0);
                if (i == rsp_dly) begin
                    mem_rsp_valid = 1'b1; mem_rsp_err = berr; mem_rdata = rdata;
                end
                tick();
            end
            mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0; mem_rdata = $urandom;
            eerr = berr;
        end else begin
            eerr = 1'b1;
        end
        eres = (!eerr && !op[3]) ? m_load(op, addr, rdata) : 32'd0;
        for (int i = 0; i <= out_dly; i++) begin
            chk({nm, ".out_valid"}, 32'(out_valid), 32'd1);
            chk({nm, ".out_result"}, out_result, eres);
            chk({nm, ".out_rf_wen"}, 32'(out_rf_wen), 32'(!eerr && !op[3]));
            chk({nm, ".out_err"}, 32'(out_err), 32'(eerr));
            chk({nm, ".out_rd"}, 32'(out_rd), 32'(rd));
            chk({nm, ".in_ready_done"}, 32'(in_ready), 32'd0);
            chk({nm, ".req_valid_done"}, 32'(mem_req_valid), 32'd0);
            if (i == out_dly) out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        chk({nm, ".out_valid_after"}, 32'(out_valid), 32'd0);
        chk({nm, ".in_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] raddr;
        int          sz;
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_op = '0; in_rd = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0; mem_rdata = '0;
        out_ready = 1'b0;
        tick(); tick();
        // Reset values
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst.mem_wen", 32'(mem_wen), 32'd0);
        chk("rst.mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.mem_wdata", mem_wdata, 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_result", out_result, 32'd0);
        chk("rst.out_rd", 32'(out_rd), 32'd0);
        chk("rst.out_rf_wen", 32'(out_rf_wen), 32'd0);
        chk("rst.out_err", 32'(out_err), 32'd0);
        rst = 1'b0;
        // A stray response in IDLE must be ignored.
        mem_rsp_valid = 1'b1; mem_rdata = 32'h11111111;
        tick();
        mem_rsp_valid = 1'b0;
        chk("stray.out_valid", 32'(out_valid), 32'd0);
        chk("stray.in_ready", 32'(in_ready), 32'd1);

        // Directed cases
        do_op("lw",  OP_LW,  32'h80000220, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0, 0, 5'd1);
        do_op("lb",  OP_LB,  32'h80000003, 32'h0, 32'h80FF1234, 0, 0, 1'b0, 0, 5'd2);
        do_op("lbu", OP_LBU, 32'h80000003, 32'h0, 32'h80FF1234, 0, 0, 1'b0, 0, 5'd3);
        do_op("lh",  OP_LH,  32'h80000002, 32'h0, 32'h80FF1234, 0, 0, 1'b0, 0, 5'd4);
        do_op("lhu", OP_LHU, 32'h80000002, 32'h0, 32'h80FF1234, 0, 0, 1'b0, 0, 5'd5);
        do_op("sb",  OP_SB,  32'h80000001, 32'h000000AB, 32'h0, 0, 0, 1'b0, 0, 5'd6);
        do_op("sh",  OP_SH,  32'h80000002, 32'h00001234, 32'h0, 0, 0, 1'b0, 0, 5'd7);
        do_op("mis_lw", OP_LW, 32'h80000002, 32'h0, 32'h0, 0, 0, 1'b0, 0, 5'd8);
        do_op("mis_sh", OP_SH, 32'h80000001, 32'hFFFF, 32'h0, 0, 0, 1'b0, 0, 5'd9);
        do_op("illegal", 4'b0011, 32'h80000000, 32'h0, 32'h0, 0, 0, 1'b0, 2, 5'd10);
        do_op("stall", OP_LW, 32'h80000040, 32'h0, 32'hCAFEF00D, 3, 4, 1'b1, 5, 5'd11);

        // Reset while waiting for the response, then a stale response.
        in_valid = 1'b1; in_addr = 32'h80000100; in_op = OP_LW; in_rd = 5'd12;
        tick();
        in_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstwait.in_ready", 32'(in_ready), 32'd1);
        chk("rstwait.out_valid", 32'(out_valid), 32'd0);
        mem_rsp_valid = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_rsp_valid = 1'b0;
        chk("rstwait.stale_out_valid", 32'(out_valid), 32'd0);
        chk("rstwait.stale_in_ready", 32'(in_ready), 32'd1);

        // Reset while the request is pending: mem_req_valid drops.
        in_valid = 1'b1; in_addr = 32'h80000200; in_op = OP_SB; in_wdata = 32'h77;
        tick();
        in_valid = 1'b0;
        chk("rstreq.req_valid_before", 32'(mem_req_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstreq.req_valid", 32'(mem_req_valid), 32'd0);
        chk("rstreq.in_ready", 32'(in_ready), 32'd1);
        chk("rstreq.mem_wstrb", 32'(mem_wstrb), 32'd0);

        // Randomized transactions
        for (int n = 0; n < 60; n++) begin
            sz = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            rop = {1'($urandom), 1'($urandom), 2'(sz)};
            raddr = $urandom;
            if ($urandom_range(0, 4) != 0) begin
                if (sz == 1) raddr[0] = 1'b0;
                if (sz == 2) raddr[1:0] = 2'b00;
            end
            do_op("rand", rop, raddr, $urandom, $urandom, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 3)), 5'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
